serial_frame_rx: RTL

//  Framed serial receiver. Consumes the 1-bit serial line produced by the PISO transmit stage
//  and reconstructs DATA_W-bit parallel words. Each word is checked for parity and framing.

---
 rtl/serial_frame_rx_pkg.sv | 17 +
 rtl/serial_frame_rx_if.sv | 30 +++
 rtl/serial_frame_rx_shift.sv | 49 ++++
 rtl/serial_frame_rx.sv | 138 +++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and line-level constants for the framed serial receiver.
package serial_frame_rx_pkg;

   // Receiver FSM states (3-bit encoding shared with the transmit-side framer).
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StData   = 3'd1,
      StParity = 3'd2,
      StStop   = 3'd3,
      StBreak  = 3'd4
   } rx_state_e;

   // Line levels of the framing bits; the line idles at StopBit.
   localparam logic StartBit = 1'b0;
   localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Word output handshake of the serial receiver: valid/ready plus the word and its status flags.
interface serial_frame_rx_if #(
   parameter int unsigned DATA_W = 4
) ();

   logic [DATA_W-1:0] Dout;
   logic              DoutValid;
   logic              DoutReady;
   logic              ParityErr;
   logic              FrameErr;

   // Producer side (the receiver).
   modport master (
      output Dout,
      output DoutValid,
      output ParityErr,
      output FrameErr,
      input  DoutReady
   );

   // Consumer side.
   modport slave (
      input  Dout,
      input  DoutValid,
      input  ParityErr,
      input  FrameErr,
      output DoutReady
   );

endinterface

// File: rtl/serial_frame_rx_shift.sv
// Data shift register and bit counter for the serial receiver.
// The first bit shifted in ends up in the MSB after DATA_W shifts.
module serial_frame_rx_shift #(
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              shift_en_i,
   input  logic              clear_i,
   input  logic              bit_i,
   output logic [DATA_W-1:0] data_o,
   output logic              last_bit_o
);

   localparam int unsigned       CntW    = $clog2(DATA_W);
   localparam logic [CntW-1:0]   LastCnt = CntW'(DATA_W - 1);

   logic [DATA_W-1:0] data_q, data_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   assign data_o     = data_q;
   assign last_bit_o = (cnt_q == LastCnt);

   // Next-state: shift MSB-first; the counter saturates at the last bit instead of wrapping.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (shift_en_i) begin
         data_d = {data_q[DATA_W-2:0], bit_i};
      end
      if (clear_i) begin
         cnt_d = '0;
      end else if (shift_en_i && !last_bit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits MSB first, optional parity, stop bit.
// Completed words are offered on a valid/ready interface together with parity/framing flags.
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int unsigned DATA_W     = 4,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  SerialDin,
   serial_frame_rx_if.master     out_if,
   output logic                  Overrun,
   output logic                  Busy
);

   rx_state_e         state_q, state_d;

   logic              shift_en;
   logic              clear_cnt;
   logic              capture_par;
   logic              frame_done;
   logic              last_bit;
   logic [DATA_W-1:0] sr_data;
   logic              par_err;
   logic              xfer;

   logic              parity_q, parity_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic              overrun_q, overrun_d;

   serial_frame_rx_shift #(
      .DATA_W (DATA_W)
   ) u_shift (
      .clk_i      (Clk),
      .rst_ni     (Rst_n),
      .shift_en_i (shift_en),
      .clear_i    (clear_cnt),
      .bit_i      (SerialDin),
      .data_o     (sr_data),
      .last_bit_o (last_bit)
   );

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; BREAK waits for a high line so a held-low line is never taken as a start.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (SerialDin == StartBit) state_d = StData;
         StData:   if (last_bit) state_d = PARITY_EN ? StParity : StStop;
         StParity: state_d = StStop;
         StStop:   state_d = (SerialDin == StopBit) ? StIdle : StBreak;
         StBreak:  if (SerialDin == StopBit) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      shift_en    = 1'b0;
      clear_cnt   = 1'b0;
      capture_par = 1'b0;
      frame_done  = 1'b0;
      Busy        = (state_q != StIdle);
      unique case (state_q)
         StIdle:   clear_cnt   = (SerialDin == StartBit);
         StData:   shift_en    = 1'b1;
         StParity: capture_par = 1'b1;
         StStop:   frame_done  = 1'b1;
         StBreak:  ;
         default:  ;
      endcase
   end

   // Even parity: data^parity must XOR to 0; odd parity: to 1.
   assign par_err = PARITY_EN && ((^{sr_data, parity_q}) != PARITY_ODD);
   assign xfer    = valid_q & out_if.DoutReady;

   // Output/handshake next state: load on completion unless a held word is still unaccepted.
   always_comb begin
      parity_d  = capture_par ? SerialDin : parity_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      overrun_d = 1'b0;
      if (frame_done) begin
         if (!valid_q || xfer) begin
            dout_d  = sr_data;
            valid_d = 1'b1;
            perr_d  = par_err;
            ferr_d  = (SerialDin != StopBit);
         end else begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   // Output/handshake registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         parity_q  <= 1'b0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         parity_q  <= parity_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_if.Dout      = dout_q;
   assign out_if.DoutValid = valid_q;
   assign out_if.ParityErr = perr_q;
   assign out_if.FrameErr  = ferr_q;
   assign Overrun          = overrun_q;

endmodule
